// File: rtl/ov7670_stream_gen.sv
// OV7670 camera-bus transmitter: PCLK at CLK/2, HREF/VSYNC framing and RGB565 test patterns.
// All bus outputs change only on the CLK edge where PCLK falls, so the receiver sees stable data on PCLK rising.
module ov7670_stream_gen #(
    parameter int H_ACTIVE    = 176,
    parameter int V_ACTIVE    = 144,
    parameter int H_BLANK     = 32,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [1:0]  PATTERN,
    input  logic [15:0] COLOR_IN,
    output logic        PCLK,
    output logic        HREF,
    output logic        VSYNC,
    output logic [7:0]  DATA,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int MAX_LINES = max2(max2(VSYNC_LINES, V_BACK), max2(V_ACTIVE, V_FRONT));
    localparam int BYTE_W    = (LINE_LEN > 2) ? $clog2(LINE_LEN) : 2;
    localparam int LINE_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int BAR_W     = H_ACTIVE / 8;
    localparam int BAR_CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    state_t              state_reg, state_next;
    logic                ph_reg;
    logic [BYTE_W-1:0]   byte_cnt_reg, byte_next;
    logic [LINE_W-1:0]   line_cnt_reg, line_next;
    logic [LINE_W-1:0]   last_line;
    logic [2:0]          bar_idx_reg, bar_idx_next;
    logic [BAR_CW-1:0]   bar_px_reg, bar_px_next;
    logic [1:0]          pattern_reg, pattern_next;
    logic [15:0]         color_reg, color_next;
    logic                href_reg, href_next;
    logic                vsync_reg;
    logic                busy_reg;
    logic [7:0]          data_reg, data_next;
    logic                frame_done_reg, done_next;
    logic                latch;
    logic                byte_last, line_last;
    logic [7:0]          x_pix, y_pix;
    logic [15:0]         pixel;

    always_comb begin
        last_line = '0;
        case (state_reg)
            ST_VSYNC:  last_line = LINE_W'(VSYNC_LINES - 1);
            ST_VBACK:  last_line = LINE_W'(V_BACK - 1);
            ST_ACTIVE: last_line = LINE_W'(V_ACTIVE - 1);
            ST_VFRONT: last_line = LINE_W'(V_FRONT - 1);
            default:   last_line = '0;
        endcase
    end

    assign byte_last = (byte_cnt_reg == BYTE_W'(LINE_LEN - 1));
    assign line_last = (line_cnt_reg == last_line);

    // Position the bus will show after the coming PCLK-falling update.
    always_comb begin
        state_next = state_reg;
        byte_next  = byte_cnt_reg;
        line_next  = line_cnt_reg;
        latch      = 1'b0;
        done_next  = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (ENABLE) begin
                state_next = ST_VSYNC;
                byte_next  = '0;
                line_next  = '0;
                latch      = 1'b1;
            end
        end else if (!byte_last) begin
            byte_next = byte_cnt_reg + BYTE_W'(1);
        end else begin
            byte_next = '0;
            if (!line_last) begin
                line_next = line_cnt_reg + LINE_W'(1);
            end else begin
                line_next = '0;
                case (state_reg)
                    ST_VSYNC:  state_next = ST_VBACK;
                    ST_VBACK:  state_next = ST_ACTIVE;
                    ST_ACTIVE: state_next = ST_VFRONT;
                    default: begin
                        done_next = 1'b1;
                        if (ENABLE) begin
                            state_next = ST_VSYNC;
                            latch      = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign pattern_next = latch ? PATTERN : pattern_reg;
    assign color_next   = latch ? COLOR_IN : color_reg;
    assign href_next    = (state_next == ST_ACTIVE) && (byte_next < BYTE_W'(2 * H_ACTIVE));

    // Bar index stepped by a pixel-width counter, restarted at the first byte of every line.
    always_comb begin
        bar_idx_next = bar_idx_reg;
        bar_px_next  = bar_px_reg;
        if (!href_next || byte_next == '0) begin
            bar_idx_next = '0;
            bar_px_next  = '0;
        end else if (!byte_next[0]) begin
            if (bar_px_reg == BAR_CW'(BAR_W - 1)) begin
                bar_px_next  = '0;
                bar_idx_next = bar_idx_reg + 3'd1;
            end else begin
                bar_px_next = bar_px_reg + BAR_CW'(1);
            end
        end
    end

    assign x_pix = 8'(byte_next >> 1);
    assign y_pix = 8'(line_next);

    always_comb begin
        pixel = 16'h0000;
        case (pattern_next)
            2'd0:    pixel = color_next;
            2'd1:    pixel = bar_color(bar_idx_next);
            2'd2:    pixel = {y_pix, x_pix};
            default: pixel = (x_pix[3] ^ y_pix[3]) ? 16'hFFFF : 16'h0000;
        endcase
        data_next = 8'h00;
        if (href_next) begin
            data_next = byte_next[0] ? pixel[7:0] : pixel[15:8];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg      <= ST_IDLE;
            ph_reg         <= 1'b0;
            byte_cnt_reg   <= '0;
            line_cnt_reg   <= '0;
            bar_idx_reg    <= '0;
            bar_px_reg     <= '0;
            pattern_reg    <= '0;
            color_reg      <= '0;
            href_reg       <= 1'b0;
            vsync_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            data_reg       <= 8'h00;
            frame_done_reg <= 1'b0;
        end else begin
            ph_reg         <= ~ph_reg;
            frame_done_reg <= 1'b0;
            if (ph_reg) begin
                state_reg      <= state_next;
                byte_cnt_reg   <= byte_next;
                line_cnt_reg   <= line_next;
                bar_idx_reg    <= bar_idx_next;
                bar_px_reg     <= bar_px_next;
                pattern_reg    <= pattern_next;
                color_reg      <= color_next;
                href_reg       <= href_next;
                vsync_reg      <= (state_next == ST_VSYNC);
                busy_reg       <= (state_next != ST_IDLE);
                data_reg       <= data_next;
                frame_done_reg <= done_next;
            end
        end
    end

    assign PCLK       = ph_reg;
    assign HREF       = href_reg;
    assign VSYNC      = vsync_reg;
    assign DATA       = data_reg;
    assign BUSY       = busy_reg;
    assign FRAME_DONE = frame_done_reg;

endmodule
